ss_stream_encoder_2bit: RTL and testbench
=========================================

# ss_stream_encoder_2bit

Sequenced transmitter for the 2-bit stochastic-symbol (SS) datapath: on a start request it latches a 9-bit binary operand and emits a fixed-length stream of 2-bit symbols whose mean equals value/128, using an internal 8-bit LFSR. It feeds the SS arithmetic blocks and the symbol-accumulating counters in place of a free-running generator with external random numbers. It adds a valid/ready handshake and an explicit start/done framing.

## Interface
- STREAM_LEN, 255: symbols per conversion; legal range 1..511.
- LFSR_SEED, 8'hA5: LFSR load value at reset and at every accepted start; must be non-zero.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- value  input  9  operand; symbol mean = value/128; exact for 0..384, values above 384 saturate.
- clear  input  1  synchronous abort; returns to IDLE next edge, no done pulse.
- ss_ready  input  1  downstream accepts the current symbol.
- ss_out  output  2  current symbol.
- ss_valid  output  1  ss_out is valid.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the last symbol is accepted.

## Operation
- Registers: state (IDLE/RUN/DONE), value_reg[8:0], lfsr[7:0], count[8:0].
- LFSR: Fibonacci, taps 8,6,5,4: fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]; next = {lfsr[6:0], fb}; period 255.
- Symbol: r = lfsr[6:0]; t = value_reg + r (10 bits); ss_out = (t >= 384) ? 3 : t[8:7]. Driven from registers only. It is 0 when not in RUN.
- IDLE: ss_valid=0, busy=0, done=0. If start=1 and clear=0: value_reg<=value, lfsr<=LFSR_SEED, count<=0, go to RUN.
- RUN: ss_valid=1, busy=1. On ss_valid & ss_ready: lfsr advances, count<=count+1. If count==STREAM_LEN-1, go to DONE.
- While ss_ready=0, ss_out, lfsr and count are held (stall, no symbol lost).
- DONE: done=1, busy=1, ss_valid=0. Next state is IDLE unconditionally.
- start is ignored outside IDLE. value changes after acceptance have no effect.
- clear has priority over every transition, including start in IDLE and the last handshake in RUN. Next state is IDLE with count<=0. lfsr and value_reg are kept.
- Sum of all emitted symbols over a full stream with value a multiple of 128 = (value/128)*STREAM_LEN exactly.

## Timing
- Reset values: state=IDLE, lfsr=LFSR_SEED, value_reg=0, count=0. Outputs: ss_out=0, ss_valid=0, busy=0, done=0.
- Reset asserted mid-stream aborts immediately (asynchronous). No done pulse is produced.
- Start latency: start sampled at edge E; first valid symbol is presented in the cycle after E.
- With ss_ready tied high: symbols occupy STREAM_LEN consecutive cycles. done is high in the following cycle. The next start can be accepted one cycle after done, so back-to-back conversions take STREAM_LEN+2 cycles each.
- First symbol of every conversion uses r = LFSR_SEED[6:0], so streams are repeatable.
- Each ss_ready low cycle during RUN extends the stream by exactly one cycle.

## Test plan
- Reset, then value=128, start pulse, ss_ready=1 -> 255 consecutive symbols all 1, then done for exactly 1 cycle, busy low after it; accumulated sum = 255.
- value=0 and value=384 (separate runs) -> all symbols 0 (sum 0) and all symbols 3 (sum 765); value=511 -> all 3 (saturation).
- value=64, ss_ready=1 -> first symbol = (64+0x25)>>7 = 0. Per-cycle symbols match the LFSR reference model. Sum equals the model sum, within ±2 of 127.5.
- Random ss_ready with ~50% duty cycle, value=200 -> symbol sequence identical to the ss_ready=1 run. ss_out is stable while stalled. done occurs after the 255th accepted symbol.
- start pulsed during RUN with a different value -> ignored; stream unchanged. clear at symbol 100 -> IDLE next edge, no done, ss_valid=0. A new start then produces a stream identical to a fresh run.
- rst asserted asynchronously mid-stream -> all outputs 0 immediately. lfsr=LFSR_SEED after release. STREAM_LEN=1 run -> single symbol, then done.

Source files
------------

// File: rtl/ss_stream_encoder_2bit.sv
// -----------------------------------------------------------------------------
// ss_stream_encoder_2bit
//
// Sequenced transmitter for the 2-bit stochastic-symbol datapath. A start
// request latches a 9-bit operand. The block then emits STREAM_LEN 2-bit
// symbols whose mean is value/128. The randomness comes from an internal
// 8-bit Fibonacci LFSR, which is reloaded with LFSR_SEED on every accepted
// start, so every stream for a given operand is repeatable.
//
// Parameters
//   STREAM_LEN  symbols per conversion, 1..511
//   LFSR_SEED   LFSR load value at reset and at every accepted start, non-zero
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   conversion request, sampled only in IDLE
//   value      in   9-bit operand, symbol mean = value/128 (saturates above 384)
//   clear      in   synchronous abort back to IDLE, no done pulse
//   ss_ready   in   downstream accepts the current symbol
//   ss_out     out  current symbol (0 outside RUN)
//   ss_valid   out  ss_out is valid (high in RUN)
//   busy       out  high in RUN and DONE
//   done       out  one-cycle pulse after the last symbol is accepted
//   dbg_state  out  FSM state for observation: 0=IDLE 1=RUN 2=DONE
//
// Handshake: a symbol transfers on a rising edge where ss_valid and ss_ready
// are both high. ss_valid never drops while a symbol is pending, and ss_out
// is held unchanged for as long as ss_ready stays low, so no symbol is lost.
// -----------------------------------------------------------------------------
module ss_stream_encoder_2bit #(
  parameter int         STREAM_LEN = 255,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] value,
  input  logic       clear,
  input  logic       ss_ready,
  output logic [1:0] ss_out,
  output logic       ss_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the final symbol; the stream ends when this one is accepted.
  localparam logic [8:0] LAST_IDX = 9'(STREAM_LEN - 1);

  // Operand + random threshold at or above this value saturates to symbol 3.
  localparam logic [9:0] SAT_LEVEL = 10'd384;

  state_t     state;
  logic [8:0] value_reg;
  logic [7:0] lfsr;
  logic [8:0] count;

  logic [7:0] lfsr_next;
  logic [9:0] sum_t;
  logic [1:0] sym;
  logic       xfer;

  // Fibonacci LFSR, taps 8,6,5,4 (maximal length, period 255).
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // The symbol is floor((value + r) / 128) with r uniform over the low seven
  // LFSR bits, which gives a mean of value/128 over a full LFSR period.
  // Results of 3 or more are clamped to the largest 2-bit symbol.
  assign sum_t = {1'b0, value_reg} + {3'b000, lfsr[6:0]};
  assign sym   = (sum_t >= SAT_LEVEL) ? 2'd3 : sum_t[8:7];

  assign xfer = (state == S_RUN) && ss_ready;

  // Status outputs are decoded straight from the state register and the
  // symbol only from value_reg/lfsr, so nothing depends on input timing.
  assign ss_valid  = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign ss_out    = (state == S_RUN) ? sym : 2'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      value_reg <= 9'd0;
      lfsr      <= LFSR_SEED;
      count     <= 9'd0;
    end else if (clear) begin
      // Abort wins over every transition. lfsr and value_reg are kept; the
      // next accepted start reloads both anyway.
      state <= S_IDLE;
      count <= 9'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            value_reg <= value;
            lfsr      <= LFSR_SEED;
            count     <= 9'd0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            lfsr  <= lfsr_next;
            count <= count + 9'd1;
            if (count == LAST_IDX) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_stream_encoder_2bit.sv
// -----------------------------------------------------------------------------
// tb_ss_stream_encoder_2bit
//
// Bench for ss_stream_encoder_2bit. One instance uses the default 255-symbol
// stream, a second uses STREAM_LEN=1. Expected symbols come from a reference
// model: a table of the 255 LFSR states and the rule
// symbol = min(3, floor((value + (state mod 128)) / 128)).
// -----------------------------------------------------------------------------
module tb_ss_stream_encoder_2bit;

  localparam int LEN = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (STREAM_LEN = 255) ----------------
  logic       start, clear, ss_ready;
  logic [8:0] value;
  logic [1:0] ss_out, dbg_state;
  logic       ss_valid, busy, done;

  ss_stream_encoder_2bit #(.STREAM_LEN(LEN), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .clear(clear),
    .ss_ready(ss_ready), .ss_out(ss_out), .ss_valid(ss_valid), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- DUT (STREAM_LEN = 1) ----------------
  logic       start1;
  logic [8:0] value1;
  logic       clear1 = 1'b0;
  logic       ready1 = 1'b1;
  logic [1:0] ss_out1, dbg_state1;
  logic       ss_valid1, busy1, done1;

  ss_stream_encoder_2bit #(.STREAM_LEN(1), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .value(value1), .clear(clear1),
    .ss_ready(ready1), .ss_out(ss_out1), .ss_valid(ss_valid1), .busy(busy1),
    .done(done1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  int lfsr_seq[LEN];
  logic [1:0] exp_q[$];

  typedef struct {
    logic [8:0] value;
    logic [1:0] first_sym;
    int         sum;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void build_lfsr_table();
    int s;
    int fb;
    s = 'hA5;
    for (int i = 0; i < LEN; i++) begin
      lfsr_seq[i] = s;
      fb = ((s / 128) + (s / 32) + (s / 16) + (s / 8)) % 2;
      s = ((s * 2) % 256) + fb;
    end
  endfunction

  function automatic int exp_sym(input int v, input int idx);
    int q;
    q = (v + (lfsr_seq[idx % LEN] % 128)) / 128;
    return (q > 3) ? 3 : q;
  endfunction

  function automatic int model_sum(input int v);
    int s;
    s = 0;
    for (int i = 0; i < LEN; i++) s += exp_sym(v, i);
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion from IDLE and follows it until done, an abort, or a
  // cycle budget. ready_pct is the ss_ready duty cycle. clear is raised when
  // clear_at symbols have been accepted; a foreign start is pulsed on RUN
  // cycle restart_at.
  task automatic run_conv(input logic [8:0] v, input int ready_pct,
                          input int clear_at, input int restart_at,
                          output int nacc, output int sum, output int cycles,
                          output int stalls, output int first_sym,
                          output bit got_done);
    bit         prev_stall;
    logic [1:0] prev_sym;
    bit         timed_out;
    nacc = 0; sum = 0; cycles = 0; stalls = 0; first_sym = -1;
    got_done = 0; prev_stall = 0; prev_sym = 2'd0; timed_out = 1;
    exp_q.delete();
    for (int i = 0; i < LEN; i++) exp_q.push_back(2'(exp_sym(int'(v), i)));

    value = v;
    start = 1'b1;
    step();
    start = 1'b0;
    value = 9'($urandom_range(0, 511));

    while (cycles < 2000) begin
      if (done) begin
        got_done = 1; timed_out = 0;
        break;
      end
      if (!ss_valid) begin
        timed_out = 0;
        break;
      end
      if (prev_stall) chk("stall_hold", ss_out, prev_sym);
      ss_ready = ($urandom_range(0, 99) < ready_pct);
      if (nacc == clear_at) begin
        clear    = 1'b1;
        ss_ready = 1'b1;
      end
      if (cycles == restart_at) begin
        start = 1'b1;
        value = 9'h1C3;
      end
      if (ss_ready && !clear) begin
        if (nacc == 0) first_sym = int'(ss_out);
        if (exp_q.size() == 0) chk("extra_symbol", nacc, LEN);
        else chk($sformatf("sym%0d", nacc), ss_out, exp_q.pop_front());
        sum += int'(ss_out);
        nacc++;
      end
      if (!ss_ready) stalls++;
      prev_stall = !ss_ready;
      prev_sym   = ss_out;
      step();
      cycles++;
      clear = 1'b0;
      start = 1'b0;
    end
    ss_ready = 1'b1;
    if (timed_out) chk("timeout", cycles, 0);
  endtask

  // Sampled in the done cycle: checks the done framing, then asserts start
  // while in DONE (must be ignored) and checks the return to IDLE.
  task automatic finish_check(input string tag);
    chk({tag, "_done_valid"}, ss_valid, 0);
    chk({tag, "_done_out"}, ss_out, 0);
    chk({tag, "_done_busy"}, busy, 1);
    start = 1'b1;
    value = 9'h080;
    step();
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nacc, sum, cycles, stalls, first_sym;
    bit got_done;
    logic [8:0] rv;

    build_lfsr_table();
    vecs[0] = '{9'd128, 2'd1, 255};
    vecs[1] = '{9'd0,   2'd0, 0};
    vecs[2] = '{9'd384, 2'd3, 765};
    vecs[3] = '{9'd511, 2'd3, 765};
    vecs[4] = '{9'd256, 2'd2, 510};
    vecs[5] = '{9'd64,  2'd0, 128};
    vecs[6] = '{9'd383, 2'd3, 764};

    start = 0; clear = 0; ss_ready = 1; value = 0;
    start1 = 0; value1 = 0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_outputs", {ss_out, ss_valid, busy, done}, 0);
    rst = 1'b0;
    step();

    chk("reset_outputs", {ss_out, ss_valid, busy, done}, 0);
    chk("reset_state", dbg_state, 0);
    chk("reset_lfsr", dut.lfsr, 8'hA5);
    chk("reset_value_reg", dut.value_reg, 0);
    chk("reset_count", dut.count, 0);

    // Single-symbol stream on the STREAM_LEN=1 instance.
    value1 = 9'd200;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("len1_valid", ss_valid1, 1);
    chk("len1_sym", ss_out1, exp_sym(200, 0));
    step();
    chk("len1_done", done1, 1);
    chk("len1_done_valid", ss_valid1, 0);
    step();
    chk("len1_done_pulse", done1, 0);
    chk("len1_idle", busy1, 0);

    // clear beats start in IDLE.
    start = 1'b1; clear = 1'b1; value = 9'd128;
    step();
    start = 1'b0; clear = 1'b0;
    chk("clear_over_start", busy, 0);

    // Table-driven full streams, ss_ready tied high, back to back.
    for (int k = 0; k < 7; k++) begin
      run_conv(vecs[k].value, 100, -1, -1, nacc, sum, cycles, stalls, first_sym, got_done);
      chk($sformatf("v%0d_first", vecs[k].value), first_sym, vecs[k].first_sym);
      chk($sformatf("v%0d_sum", vecs[k].value), sum, vecs[k].sum);
      chk($sformatf("v%0d_cycles", vecs[k].value), cycles, LEN);
      chk($sformatf("v%0d_done", vecs[k].value), got_done, 1);
      if (vecs[k].value == 9'd64) chk("v64_sum_range", (sum >= 126 && sum <= 129), 1);
      finish_check($sformatf("v%0d", vecs[k].value));
    end

    // value=200 with ~50% ss_ready: same symbols as an unstalled run.
    run_conv(9'd200, 50, -1, -1, nacc, sum, cycles, stalls, first_sym, got_done);
    chk("rnd200_sum", sum, model_sum(200));
    chk("rnd200_count", nacc, LEN);
    chk("rnd200_cycles", cycles, LEN + stalls);
    chk("rnd200_done", got_done, 1);
    finish_check("rnd200");

    // Random operands and duty cycles.
    for (int k = 0; k < 4; k++) begin
      rv = 9'($urandom_range(0, 511));
      run_conv(rv, $urandom_range(30, 90), -1, -1, nacc, sum, cycles, stalls, first_sym, got_done);
      chk($sformatf("rnd%0d_sum", rv), sum, model_sum(int'(rv)));
      chk($sformatf("rnd%0d_cycles", rv), cycles, LEN + stalls);
      chk($sformatf("rnd%0d_done", rv), got_done, 1);
      finish_check("rnd");
    end

    // start with another value during RUN is ignored.
    run_conv(9'd200, 100, -1, 10, nacc, sum, cycles, stalls, first_sym, got_done);
    chk("restart_sum", sum, model_sum(200));
    chk("restart_cycles", cycles, LEN);
    chk("restart_done", got_done, 1);
    finish_check("restart");

    // clear at symbol 100: IDLE next edge, no done.
    run_conv(9'd200, 100, 100, -1, nacc, sum, cycles, stalls, first_sym, got_done);
    chk("clear_nacc", nacc, 100);
    chk("clear_no_done", got_done, 0);
    chk("clear_valid", ss_valid, 0);
    chk("clear_busy", busy, 0);
    chk("clear_count", dut.count, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("clear_quiet", {done, busy, ss_valid}, 0);
    end
    run_conv(9'd200, 100, -1, -1, nacc, sum, cycles, stalls, first_sym, got_done);
    chk("after_clear_sum", sum, model_sum(200));
    chk("after_clear_done", got_done, 1);
    finish_check("after_clear");

    // Asynchronous reset mid-stream.
    value = 9'd300;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {ss_out, ss_valid, busy, done}, 0);
    chk("async_rst_lfsr", dut.lfsr, 8'hA5);
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("post_rst_quiet", {done, busy, ss_valid}, 0);
    end
    chk("post_rst_lfsr", dut.lfsr, 8'hA5);
    run_conv(9'd64, 100, -1, -1, nacc, sum, cycles, stalls, first_sym, got_done);
    chk("post_rst_first", first_sym, 0);
    chk("post_rst_sum", sum, model_sum(64));
    chk("post_rst_done", got_done, 1);
    finish_check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
